q_max_scanner: RTL

- Read-side companion to the Q-value update datapath.
- Scans the N_ACT Q-table entries of the current board state and returns the maximum Q value (max_Q) and its action index (argmax). Only legal moves are considered.
- max_q feeds the updater's max_Q input; best_act feeds greedy move selection.
- Sits between the Q-table RAM read port and the learning/decision controller.

---
 rtl/q_max_scanner.sv | 117 +++++++++++
 1 files changed

// File: rtl/q_max_scanner.sv
// Scans the N_ACT Q-table entries of one board state and returns the signed
// maximum over legal actions and its index. The lowest index wins on ties.
module q_max_scanner #(
  parameter int DATA_W = 16,
  parameter int N_ACT  = 9,
  parameter int ACT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [N_ACT-1:0]  valid_mask_i,
  output logic              q_rd_en_o,
  output logic [ACT_W-1:0]  q_rd_addr_o,
  input  logic [DATA_W-1:0] q_rd_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] max_q_o,
  output logic [ACT_W-1:0]  best_act_o,
  output logic              none_valid_o
);

  localparam int unsigned          ADDR_N = 1 << ACT_W;
  localparam logic [ACT_W-1:0]     LAST   = ACT_W'(N_ACT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t                    state_q;
  logic [N_ACT-1:0]          mask_q;
  logic [ADDR_N-1:0]         mask_ext;
  logic                      pipe_vld_q, pipe_m_q;
  logic signed [DATA_W-1:0]  run_max_q, run_max_d;
  logic [ACT_W-1:0]          run_idx_q, run_idx_d, pipe_addr_q;
  logic                      found_q, found_d, upd;

  // Widen the mask to the full address space so indexing by address is in range.
  assign mask_ext = ADDR_N'(mask_q);

  // Compare stage: the pipe registers describe the word arriving on q_rd_data_i.
  always_comb begin
    upd       = pipe_vld_q && pipe_m_q &&
                (!found_q || ($signed(q_rd_data_i) > run_max_q));
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    found_d   = found_q;
    if (upd) begin
      run_max_d = $signed(q_rd_data_i);
      run_idx_d = pipe_addr_q;
      found_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      pipe_vld_q   <= 1'b0;
      pipe_m_q     <= 1'b0;
      pipe_addr_q  <= '0;
      run_max_q    <= '0;
      run_idx_q    <= '0;
      found_q      <= 1'b0;
      q_rd_en_o    <= 1'b0;
      q_rd_addr_o  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      max_q_o      <= '0;
      best_act_o   <= '0;
      none_valid_o <= 1'b0;
    end else begin
      pipe_vld_q  <= q_rd_en_o;
      pipe_m_q    <= mask_ext[q_rd_addr_o];
      pipe_addr_q <= q_rd_addr_o;
      done_o      <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          mask_q      <= valid_mask_i;
          run_max_q   <= '0;
          run_idx_q   <= '0;
          found_q     <= 1'b0;
          busy_o      <= 1'b1;
          q_rd_en_o   <= 1'b1;
          q_rd_addr_o <= '0;
          state_q     <= SCAN;
        end
        SCAN: begin
          run_max_q <= run_max_d;
          run_idx_q <= run_idx_d;
          found_q   <= found_d;
          if (q_rd_addr_o == LAST) begin
            q_rd_en_o   <= 1'b0;
            q_rd_addr_o <= '0;
            state_q     <= FLUSH;
          end else begin
            q_rd_addr_o <= q_rd_addr_o + 1'b1;
          end
        end
        FLUSH: begin
          // Last word is compared here; publish straight from the next-state values.
          run_max_q    <= run_max_d;
          run_idx_q    <= run_idx_d;
          found_q      <= found_d;
          done_o       <= 1'b1;
          max_q_o      <= found_d ? run_max_d : '0;
          best_act_o   <= found_d ? run_idx_d : '0;
          none_valid_o <= !found_d;
          state_q      <= DONE;
        end
        DONE: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
